// File: rtl/queue_packer.sv
// Pops entries from the nibble queue and packs RATIO of them into one wide word,
// presented on a registered valid/ready port; flush closes a partial word early.
module queue_packer #(
    parameter int DATA_WIDTH = 4,
    parameter int RATIO      = 4,
    localparam int CW        = $clog2(RATIO + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_deq,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [CW-1:0]               out_count,
    output logic                        dbg_state_o
);

    localparam int WW = DATA_WIDTH * RATIO;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [WW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]   out_count_q, out_count_d;

    logic            slot_free;
    logic            accept;
    logic            load;
    logic [WW-1:0]   load_word;
    logic [CW-1:0]   load_count;

    // Output register is free if empty or being drained on this edge.
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        in_deq      = 1'b0;
        accept      = 1'b0;
        load        = 1'b0;
        load_word   = '0;
        load_count  = '0;

        case (state_q)
            FILL: begin
                in_deq = in_valid;
                accept = in_valid && in_deq;
                for (int i = 0; i < RATIO; i++) begin
                    if (accept && cnt_q == CW'(i)) begin
                        acc_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    end
                end
                if (accept && cnt_q == CW'(RATIO - 1)) begin
                    if (slot_free) begin
                        load       = 1'b1;
                        load_word  = acc_d;
                        load_count = CW'(RATIO);
                        cnt_d      = '0;
                        acc_d      = '0;
                    end else begin
                        // Full word parked in acc until the output slot frees up.
                        cnt_d   = CW'(RATIO);
                        state_d = HOLD;
                    end
                end else if (flush && (cnt_q != '0 || accept)) begin
                    if (slot_free) begin
                        // acc is cleared after every load, so unused lanes read zero.
                        load       = 1'b1;
                        load_word  = acc_d;
                        load_count = cnt_q + CW'(accept);
                        cnt_d      = '0;
                        acc_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(accept);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(accept);
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_word  = acc_q;
                    load_count = CW'(RATIO);
                    cnt_d      = '0;
                    acc_d      = '0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_word;
            out_count_d = load_count;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_count   = out_count_q;
    assign dbg_state_o = state_q;

endmodule
